pc_fetch_unit: RTL and testbench

Instruction-fetch front end that owns the architectural fetch PC and turns it into a stream of instruction-memory requests. It consumes the branch/jump target produced by the PC + immediate target adder through a redirect port and delivers in-order {pc, instruction} pairs to decode over a valid/ready handshake. It holds at most two fetches in flight or buffered, and discards wrong-path responses after a redirect.

---
 rtl/pc_fetch_unit_if.sv | 45 ++++
 rtl/pc_fetch_unit.sv | 219 +++++++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
//==============================================================================
// Module      : pc_fetch_unit_if
// Description : Bundle of the fetch front-end buses: redirect input from the
//               target adder, instruction-memory request/response, and the
//               {pc, instruction} handshake towards decode.
//   master : the fetch unit side (drives requests and instructions)
//   slave  : the environment side (memory, decode, branch resolution)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface pc_fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready;
  logic        misalign_trap;

  modport master (
    input  redirect_valid, redirect_target,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  inst_ready,
    output imem_req_valid, imem_req_addr,
    output inst_valid, inst_pc, inst_data,
    output misalign_trap
  );

  modport slave (
    output redirect_valid, redirect_target,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output inst_ready,
    input  imem_req_valid, imem_req_addr,
    input  inst_valid, inst_pc, inst_data,
    input  misalign_trap
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
//==============================================================================
// Module      : pc_fetch_unit
// Description : Instruction-fetch front end. Owns the fetch PC, issues
//               in-order instruction-memory requests under a two-credit
//               budget, tags responses with their PC and hands
//               {pc, instruction} pairs to decode. Redirects flush all
//               buffered state and discard wrong-path responses.
// Ports       : clk            - clock, rising edge
//               rst_n          - asynchronous active-low reset
//               bus (master)   - redirect_valid/redirect_target in,
//                                imem_req_valid/addr out, imem_req_ready in,
//                                imem_resp_valid/data in,
//                                inst_valid/pc/data out, inst_ready in,
//                                misalign_trap out
// Parameters  : RESET_PC       - fetch address after reset
// Macro       : FETCH_MISALIGN_TRAP_EN - when defined, a redirect to a
//               non-word-aligned target flushes and parks the unit in a
//               sticky trap state; otherwise the low target bits are dropped.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  pc_fetch_unit_if.master bus
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_TRAP = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_fetch_pc;
  logic [1:0]  r_outstanding;
  logic [1:0]  r_drop_cnt;

  // Tag FIFO: PCs of requests whose responses will be kept (head = r_tag0).
  logic [31:0] r_tag0;
  logic [31:0] r_tag1;
  logic [1:0]  r_tag_cnt;

  // Output buffer entries are {pc, data}; head = r_buf0.
  logic [63:0] r_buf0;
  logic [63:0] r_buf1;
  logic [1:0]  r_buf_cnt;

  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_inst_valid;
  logic        w_pop;
  logic [2:0]  w_credit_used;
  logic        w_req_valid;
  logic        w_accept;
  logic        w_resp;
  logic        w_keep;
  logic [63:0] w_push_entry;
  logic        w_unused_tgt;

  assign w_redirect = bus.redirect_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign    = |bus.redirect_target[1:0];
  assign w_redirect_pc = bus.redirect_target;
`else
  assign w_redirect_pc = {bus.redirect_target[31:2], 2'b00};
`endif
  assign w_unused_tgt = ^bus.redirect_target[1:0];

  // Decode never sees an instruction in a redirect cycle: the buffer is
  // being flushed, so nothing may be popped either.
  assign w_inst_valid = (r_buf_cnt != 2'd0) && !w_redirect;
  assign w_pop        = w_inst_valid && bus.inst_ready;

  // Credits count requests in flight (including ones that will be dropped)
  // plus buffered instructions; a same-cycle pop frees one immediately.
  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, r_buf_cnt} - {2'b00, w_pop};
  assign w_req_valid   = (r_state == S_RUN) && !w_redirect && (w_credit_used < 3'd2);
  assign w_accept      = w_req_valid && bus.imem_req_ready;

  assign w_resp       = bus.imem_resp_valid;
  assign w_keep       = w_resp && (r_drop_cnt == 2'd0) && !w_redirect;
  assign w_push_entry = {r_tag0, bus.imem_resp_data};

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.inst_valid     = w_inst_valid;
  assign bus.inst_pc        = r_buf0[63:32];
  assign bus.inst_data      = r_buf0[31:0];

`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.misalign_trap = (r_state == S_TRAP);
`else
  assign bus.misalign_trap = 1'b0;
`endif

  // State machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
    end else begin
      case (r_state)
        S_BOOT: r_state <= S_RUN;
        S_RUN: begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (w_redirect && w_misalign) begin
            r_state <= S_TRAP;
          end
`endif
        end
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_BOOT;
      endcase
    end
  end

  // Fetch PC and in-flight bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= 2'd0;
      r_drop_cnt    <= 2'd0;
    end else begin
      // Every response retires one in-flight request, kept or not.
      r_outstanding <= r_outstanding + {1'b0, w_accept} - {1'b0, w_resp};
      if (w_redirect) begin
        r_fetch_pc <= w_redirect_pc;
        // A response arriving in the redirect cycle is itself discarded,
        // so only the remaining in-flight requests need dropping later.
        r_drop_cnt <= r_outstanding - {1'b0, w_resp};
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_resp && (r_drop_cnt != 2'd0)) begin
          r_drop_cnt <= r_drop_cnt - 2'd1;
        end
      end
    end
  end

  // Tag FIFO: push on accept, pop on every kept response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag0    <= 32'd0;
      r_tag1    <= 32'd0;
      r_tag_cnt <= 2'd0;
    end else if (w_redirect) begin
      r_tag_cnt <= 2'd0;
    end else begin
      case ({w_accept, w_keep})
        2'b10: begin
          if (r_tag_cnt == 2'd0) begin
            r_tag0 <= r_fetch_pc;
          end else begin
            r_tag1 <= r_fetch_pc;
          end
          r_tag_cnt <= r_tag_cnt + 2'd1;
        end
        2'b01: begin
          r_tag0    <= r_tag1;
          r_tag_cnt <= r_tag_cnt - 2'd1;
        end
        2'b11: begin
          if (r_tag_cnt == 2'd2) begin
            r_tag0 <= r_tag1;
            r_tag1 <= r_fetch_pc;
          end else begin
            r_tag0 <= r_fetch_pc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output buffer: push on kept response, pop on decode handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf0    <= 64'd0;
      r_buf1    <= 64'd0;
      r_buf_cnt <= 2'd0;
    end else if (w_redirect) begin
      r_buf_cnt <= 2'd0;
    end else begin
      case ({w_keep, w_pop})
        2'b10: begin
          if (r_buf_cnt == 2'd0) begin
            r_buf0 <= w_push_entry;
          end else begin
            r_buf1 <= w_push_entry;
          end
          r_buf_cnt <= r_buf_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0    <= r_buf1;
          r_buf_cnt <= r_buf_cnt - 2'd1;
        end
        2'b11: begin
          if (r_buf_cnt == 2'd2) begin
            r_buf0 <= r_buf1;
            r_buf1 <= w_push_entry;
          end else begin
            r_buf0 <= w_push_entry;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
//==============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed self-checking bench for pc_fetch_unit with an
//               in-order instruction memory model (data = ~address) whose
//               responses can be held back to build up in-flight requests.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pc_fetch_unit;

  logic clk;
  logic rst_n;
  logic mem_hold;
  int   checks;
  int   errors;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: one-cycle latency unless held; responses in order.
  logic [31:0] mem_q[$];
  logic        mem_acc;
  logic [31:0] mem_addr;
  logic        mem_rv;
  logic [31:0] mem_rd;

  always @(posedge clk) begin
    mem_acc  = rst_n && bus.imem_req_valid && bus.imem_req_ready;
    mem_addr = bus.imem_req_addr;
    mem_rv   = 1'b0;
    mem_rd   = 32'd0;
    if (!rst_n) begin
      mem_q.delete();
    end else begin
      if (mem_acc) mem_q.push_back(mem_addr);
      if (!mem_hold && mem_q.size() > 0) begin
        mem_rv = 1'b1;
        mem_rd = ~mem_q.pop_front();
      end
    end
    #1;
    bus.imem_resp_valid = mem_rv;
    bus.imem_resp_data  = mem_rd;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    mem_hold = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'd0;
    bus.imem_req_ready  = 1'b1;
    bus.inst_ready      = 1'b1;

    // Reset values
    tick();
    tick();
    settle();
    chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_trap", {31'd0, bus.misalign_trap}, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_inst_data", bus.inst_data, 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, 32'd0);

    // Cycle 0 after release: boot cycle, no request
    tick();
    rst_n = 1'b1;
    settle();
    chk("boot_no_req", {31'd0, bus.imem_req_valid}, 32'd0);

    // Cycles 1..8: streaming, first instruction at cycle 3
    for (int k = 1; k <= 8; k++) begin
      tick();
      settle();
      chk("stream_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
      chk("stream_req_addr", bus.imem_req_addr, 32'(4 * (k - 1)));
      if (k >= 3) begin
        chk("stream_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
        chk("stream_inst_pc", bus.inst_pc, 32'(4 * (k - 3)));
        chk("stream_inst_data", bus.inst_data, ~32'(4 * (k - 3)));
      end else begin
        chk("stream_inst_empty", {31'd0, bus.inst_valid}, 32'd0);
      end
    end

    // Cycle 9: decode stalls; both credits are in use
    tick();
    bus.inst_ready = 1'b0;
    settle();
    chk("stall_req_off", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("stall_inst_pc", bus.inst_pc, 32'h18);
    repeat (9) tick();
    settle();
    chk("stall_req_still_off", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("stall_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("stall_inst_pc_held", bus.inst_pc, 32'h18);

    // Cycle 19: release, no loss or duplication
    tick();
    bus.inst_ready = 1'b1;
    settle();
    chk("release_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("release_req_addr", bus.imem_req_addr, 32'h20);
    chk("release_inst_pc", bus.inst_pc, 32'h18);
    for (int k = 1; k <= 2; k++) begin
      tick();
      settle();
      chk("release_seq_pc", bus.inst_pc, 32'h18 + 32'(4 * k));
      chk("release_seq_data", bus.inst_data, ~(32'h18 + 32'(4 * k)));
    end

    // Cycle 22: memory starts holding responses; two requests pile up
    tick();
    mem_hold = 1'b1;
    settle();
    chk("hold_inst_pc", bus.inst_pc, 32'h24);
    chk("hold_req_addr", bus.imem_req_addr, 32'h2C);
    repeat (3) tick();
    tick();
    mem_hold = 1'b0;
    settle();
    chk("two_out_req_off", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("two_out_inst_empty", {31'd0, bus.inst_valid}, 32'd0);

    // Cycle 27: redirect to 0x100 while the first stale response arrives
    tick();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h100;
    settle();
    chk("redir_req_off", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("redir_inst_off", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    settle();
    chk("redir_next_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("redir_next_req_addr", bus.imem_req_addr, 32'h100);
    chk("redir_drop1", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    settle();
    chk("redir_drop2", {31'd0, bus.inst_valid}, 32'd0);
    chk("redir_req_addr2", bus.imem_req_addr, 32'h104);
    tick();
    settle();
    chk("redir_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("redir_inst_pc", bus.inst_pc, 32'h100);
    chk("redir_inst_data", bus.inst_data, ~32'h100);

    // Cycle 31: redirect with a response and a pending pop in the same cycle
    tick();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    settle();
    chk("redir_pop_inst_off", {31'd0, bus.inst_valid}, 32'd0);
    chk("redir_pop_req_off", {31'd0, bus.imem_req_valid}, 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    settle();
    chk("wrap_req_addr0", bus.imem_req_addr, 32'hFFFF_FFFC);
    chk("wrap_req_valid0", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("wrap_inst_empty", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    settle();
    chk("wrap_req_addr1", bus.imem_req_addr, 32'h0);
    chk("wrap_inst_empty2", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    settle();
    chk("wrap_inst_pc0", bus.inst_pc, 32'hFFFF_FFFC);
    chk("wrap_inst_data0", bus.inst_data, 32'h0000_0003);
    chk("wrap_req_addr2", bus.imem_req_addr, 32'h4);
    tick();
    settle();
    chk("wrap_inst_pc1", bus.inst_pc, 32'h0);

    // Cycle 36: misaligned redirect
    tick();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h102;
    settle();
    chk("misalign_redir_req_off", {31'd0, bus.imem_req_valid}, 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    settle();
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("trap_flag", {31'd0, bus.misalign_trap}, 32'd1);
    chk("trap_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    tick();
    tick();
    settle();
    chk("trap_flag_sticky", {31'd0, bus.misalign_trap}, 32'd1);
    chk("trap_no_req_later", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("trap_no_inst", {31'd0, bus.inst_valid}, 32'd0);
`else
    chk("align_no_trap", {31'd0, bus.misalign_trap}, 32'd0);
    chk("align_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("align_req_addr", bus.imem_req_addr, 32'h100);
    tick();
    tick();
    settle();
    chk("align_inst_pc", bus.inst_pc, 32'h100);
    chk("align_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
`endif

    // Mid-operation reset clears everything immediately
    tick();
    rst_n = 1'b0;
    settle();
    chk("midrst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("midrst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("midrst_req_addr", bus.imem_req_addr, 32'd0);
    chk("midrst_inst_pc", bus.inst_pc, 32'd0);
    chk("midrst_trap", {31'd0, bus.misalign_trap}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    chk("midrst_boot_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    tick();
    settle();
    chk("midrst_first_req", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("midrst_first_addr", bus.imem_req_addr, 32'd0);
    tick();
    tick();
    settle();
    chk("midrst_first_inst_pc", bus.inst_pc, 32'd0);
    chk("midrst_first_inst_valid", {31'd0, bus.inst_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
